// File: rtl/mil_tx_msg_if.sv
// Word-input handshake of the MIL-STD-1553 message transmitter.
// The master offers {s_cmd, s_last, s_data} with s_valid; the transmitter accepts on s_ready.
interface mil_tx_msg_if;
    logic [15:0] s_data;
    logic        s_cmd;
    logic        s_last;
    logic        s_valid;
    logic        s_ready;

    modport master (output s_data, s_cmd, s_last, s_valid, input s_ready);
    modport slave  (input s_data, s_cmd, s_last, s_valid, output s_ready);
endinterface

// File: rtl/mil_tx_msg.sv
// MIL-STD-1553 Manchester II message transmitter: word FIFO, sync/data/parity encoder
// and enforced inter-message idle gap, with level-sensitive inhibit/abort.
module mil_tx_msg #(
    parameter int FCLK_HZ  = 50000000,
    parameter int BIT_HZ   = 1000000,
    parameter int DEPTH    = 32,
    parameter int GAP_BITS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mil_tx_msg_if.slave            bus,
    input  logic                   inh,
    output logic                   TXP,
    output logic                   TXN,
    output logic                   tx_en,
    output logic                   busy,
    output logic                   word_done,
    output logic                   msg_done,
    output logic                   underrun,
    output logic                   aborted,
    output logic [$clog2(DEPTH):0] fifo_level
);
    localparam int HALF    = FCLK_HZ / (2 * BIT_HZ);
    localparam int AW      = $clog2(DEPTH);
    localparam int GAP_LEN = GAP_BITS * 2 * HALF;
    localparam int HCW     = $clog2(HALF);
    localparam int GCW     = $clog2(GAP_LEN);

    typedef enum logic [2:0] {IDLE, SYNC, DATA, PARITY, GAP} state_t;

    // ---------------- word FIFO ----------------
    logic [17:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level, level_n;
    logic [17:0]   rd_word;
    logic          ready_en, push, pop, empty, full;

    assign empty       = (level == '0);
    assign full        = (level == (AW+1)'(DEPTH));
    assign bus.s_ready = ready_en & ~full & ~inh;
    assign push        = bus.s_valid & bus.s_ready;
    assign rd_word     = mem[rd_ptr];
    assign fifo_level  = level;

    // NOTE: storage array carries no reset; only the pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {bus.s_cmd, bus.s_last, bus.s_data};
    end

    always_comb begin
        level_n = level;
        if (inh)               level_n = '0;
        else if (push && !pop) level_n = level + 1'b1;
        else if (pop && !push) level_n = level - 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            level    <= level_n;
            if (inh) begin
                rd_ptr <= wr_ptr;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // ---------------- word sequencer ----------------
    state_t         state, state_n;
    logic [HCW-1:0] hcnt, hcnt_n;
    logic [5:0]     hidx, hidx_n;
    logic [GCW-1:0] gcnt, gcnt_n;
    logic [15:0]    word_q, word_n;
    logic           cmd_q, cmd_n, last_q, last_n;
    logic           aborted_n;

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a variable unassigned (no latches).
        state_n   = state;
        hcnt_n    = hcnt;
        hidx_n    = hidx;
        gcnt_n    = gcnt;
        word_n    = word_q;
        cmd_n     = cmd_q;
        last_n    = last_q;
        pop       = 1'b0;
        aborted_n = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty && !inh) begin
                    pop     = 1'b1;
                    state_n = SYNC;
                    hcnt_n  = '0;
                    hidx_n  = '0;
                end
            end
            SYNC, DATA, PARITY: begin
                if (inh) begin
                    state_n   = GAP;
                    gcnt_n    = '0;
                    aborted_n = 1'b1;
                end else if (hcnt != HCW'(HALF - 1)) begin
                    hcnt_n = hcnt + 1'b1;
                end else begin
                    hcnt_n = '0;
                    if (hidx == 6'd39) begin
                        hidx_n = '0;
                        // Chain straight into the next word when the message continues and data is ready.
                        if (!last_q && !empty) begin
                            pop     = 1'b1;
                            state_n = SYNC;
                        end else begin
                            state_n = GAP;
                            gcnt_n  = '0;
                        end
                    end else begin
                        hidx_n = hidx + 1'b1;
                        if (hidx == 6'd5)       state_n = DATA;
                        else if (hidx == 6'd37) state_n = PARITY;
                    end
                end
            end
            GAP: begin
                if (gcnt == GCW'(GAP_LEN - 1)) state_n = IDLE;
                else                           gcnt_n  = gcnt + 1'b1;
            end
            default: state_n = IDLE;
        endcase
        if (pop) {cmd_n, last_n, word_n} = rd_word;
    end

    // ---------------- output decode from next-state values ----------------
    logic       tx_en_n, lvl_n, word_done_n, msg_done_n, underrun_n;
    logic [4:0] dofs;

    always_comb begin
        tx_en_n = state_n inside {SYNC, DATA, PARITY};
        dofs    = 5'(hidx_n - 6'd6);
        unique case (state_n)
            SYNC:    lvl_n = cmd_n ^ (hidx_n >= 6'd3);
            DATA:    lvl_n = word_n[4'd15 - dofs[4:1]] ^ dofs[0];
            PARITY:  lvl_n = ~(^word_n) ^ hidx_n[0];
            default: lvl_n = 1'b0;
        endcase
        word_done_n = (state_n == PARITY) && (hidx_n == 6'd39) && (hcnt_n == HCW'(HALF - 1));
        msg_done_n  = word_done_n & last_n;
        // The FIFO content seen at the word's last clock is what decides chaining versus underrun.
        underrun_n  = word_done_n & ~last_n & (level_n == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hcnt      <= '0;
            hidx      <= '0;
            gcnt      <= '0;
            word_q    <= '0;
            cmd_q     <= 1'b0;
            last_q    <= 1'b0;
            TXP       <= 1'b0;
            TXN       <= 1'b0;
            tx_en     <= 1'b0;
            busy      <= 1'b0;
            word_done <= 1'b0;
            msg_done  <= 1'b0;
            underrun  <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            state     <= state_n;
            hcnt      <= hcnt_n;
            hidx      <= hidx_n;
            gcnt      <= gcnt_n;
            word_q    <= word_n;
            cmd_q     <= cmd_n;
            last_q    <= last_n;
            TXP       <= tx_en_n & lvl_n;
            TXN       <= tx_en_n & ~lvl_n;
            tx_en     <= tx_en_n;
            busy      <= (state_n != IDLE);
            word_done <= word_done_n;
            msg_done  <= msg_done_n;
            underrun  <= underrun_n;
            aborted   <= aborted_n;
        end
    end
endmodule

// File: tb/tb_mil_tx_msg.sv
// Self-checking bench for mil_tx_msg: directed and random messages compared against
// a half-bit line model computed from the Manchester/sync/parity rules.
module tb_mil_tx_msg;
    localparam int DEPTH   = 8;
    localparam int HALF    = 50_000_000 / (2 * 1_000_000);
    localparam int GAP_CLK = 4 * 2 * HALF;

    typedef struct packed {
        logic [15:0] d;
        logic        c;
        logic        l;
    } word_t;

    logic                   clk;
    logic                   rst_n;
    logic                   inh;
    logic                   TXP, TXN, tx_en, busy;
    logic                   word_done, msg_done, underrun, aborted;
    logic [$clog2(DEPTH):0] fifo_level;

    mil_tx_msg_if bus ();

    mil_tx_msg #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .inh        (inh),
        .TXP        (TXP),
        .TXN        (TXN),
        .tx_en      (tx_en),
        .busy       (busy),
        .word_done  (word_done),
        .msg_done   (msg_done),
        .underrun   (underrun),
        .aborted    (aborted),
        .fifo_level (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_cmp = 0;
    int    n_bad = 0;
    word_t msg[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Expected line level for half-bit h (0..39) of a word.
    function automatic logic exp_level(input logic [15:0] w, input logic c, input int h);
        logic b, p;
        if (h < 6) return c ? (h < 3) : (h >= 3);
        if (h < 38) begin
            b = w[15 - (h - 6) / 2];
            return ((h - 6) % 2 == 0) ? b : !b;
        end
        p = ($countones(w) % 2 == 0);
        return (h == 38) ? p : !p;
    endfunction

    // One attempt, issued at a negedge; ok reports whether the next edge accepted it.
    task automatic push(input logic [15:0] d, input logic c, input logic l, output logic ok);
        bus.s_data  = d;
        bus.s_cmd   = c;
        bus.s_last  = l;
        bus.s_valid = 1'b1;
        #1 ok = bus.s_ready;
        @(negedge clk);
        bus.s_valid = 1'b0;
    endtask

    task automatic push_msg();
        logic ok;
        foreach (msg[i]) begin
            ok = 1'b0;
            for (int t = 0; t < 20 && ok !== 1'b1; t++) push(msg[i].d, msg[i].c, msg[i].l, ok);
            check("push accepted", ok, 1);
        end
    endtask

    task automatic wait_tx(input string tag, input int limit);
        int n;
        n = 0;
        while (tx_en !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check({tag, " tx_en start"}, tx_en, 1);
    endtask

    // Starts at the negedge inside a word's first clock, ends at the negedge after its last.
    task automatic check_word(input string tag, input logic [15:0] w, input logic c,
                              input logic last, input logic exp_ur);
        int   good, wd_cnt, md_cnt, ur_cnt;
        logic lv, wd_end, md_end, ur_end;
        wd_cnt = 0; md_cnt = 0; ur_cnt = 0;
        wd_end = 1'b0; md_end = 1'b0; ur_end = 1'b0;
        for (int h = 0; h < 40; h++) begin
            good = 0;
            lv   = exp_level(w, c, h);
            for (int k = 0; k < HALF; k++) begin
                if (tx_en === 1'b1 && TXP === lv && TXN === !lv) good++;
                wd_cnt += int'(word_done === 1'b1);
                md_cnt += int'(msg_done === 1'b1);
                ur_cnt += int'(underrun === 1'b1);
                if (h == 39 && k == HALF - 1) begin
                    wd_end = word_done;
                    md_end = msg_done;
                    ur_end = underrun;
                end
                @(negedge clk);
            end
            check($sformatf("%s half-bit %0d good clocks", tag, h), good, HALF);
        end
        check({tag, " word_done at last clock"}, wd_end, 1);
        check({tag, " word_done count"}, wd_cnt, 1);
        check({tag, " msg_done at last clock"}, md_end, last);
        check({tag, " msg_done count"}, md_cnt, int'(last));
        check({tag, " underrun at last clock"}, ur_end, exp_ur);
        check({tag, " underrun count"}, ur_cnt, int'(exp_ur));
    endtask

    task automatic check_gap(input string tag);
        int quiet;
        quiet = 0;
        for (int k = 0; k < GAP_CLK; k++) begin
            if (tx_en === 1'b0 && TXP === 1'b0 && TXN === 1'b0 && busy === 1'b1) quiet++;
            @(negedge clk);
        end
        check({tag, " gap quiet clocks"}, quiet, GAP_CLK);
        check({tag, " idle after gap"}, busy, 0);
    endtask

    task automatic check_msg(input string tag);
        wait_tx(tag, 100);
        foreach (msg[i])
            check_word($sformatf("%s w%0d", tag, i), msg[i].d, msg[i].c, msg[i].l,
                       !msg[i].l && (i == msg.size() - 1));
        check_gap(tag);
    endtask

    task automatic run_msg(input string tag);
        fork
            push_msg();
            check_msg(tag);
        join
        check({tag, " fifo drained"}, fifo_level, 0);
    endtask

    initial begin
        logic        ok;
        int          n_wd, n_md, n_tx, len;
        logic [15:0] par_words [3];

        rst_n = 1'b0; inh = 1'b0;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.s_cmd = 1'b0; bus.s_last = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        check("reset outputs", {TXP, TXN, tx_en, busy, word_done, msg_done, underrun, aborted}, 0);
        check("reset level", fifo_level, 0);
        check("reset s_ready", bus.s_ready, 0);
        rst_n = 1'b1;
        #1 check("s_ready before first clk", bus.s_ready, 0);
        @(negedge clk);
        check("s_ready after first clk", bus.s_ready, 1);

        // single command word with latency
        msg.delete();
        msg.push_back('{d: 16'hA5A5, c: 1'b1, l: 1'b1});
        push(16'hA5A5, 1'b1, 1'b1, ok);
        check("single push", ok, 1);
        check("single not yet started", {busy, tx_en}, 0);
        check("single level after push", fifo_level, 1);
        @(negedge clk);
        check("single started", {busy, tx_en}, 2'b11);
        check("single popped", fifo_level, 0);
        check_word("single", 16'hA5A5, 1'b1, 1'b1, 1'b0);
        check_gap("single");

        // data-sync words and parity corners
        par_words[0] = 16'h0000; par_words[1] = 16'h0001; par_words[2] = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            msg.delete();
            msg.push_back('{d: par_words[i], c: 1'b0, l: 1'b1});
            run_msg($sformatf("parity%0d", i));
        end

        // back-to-back three-word message
        msg.delete();
        msg.push_back('{d: 16'h1234, c: 1'b1, l: 1'b0});
        msg.push_back('{d: 16'hBEEF, c: 1'b0, l: 1'b0});
        msg.push_back('{d: 16'h8001, c: 1'b0, l: 1'b1});
        run_msg("b2b");

        // underrun
        msg.delete();
        msg.push_back('{d: 16'h4321, c: 1'b1, l: 1'b0});
        run_msg("underrun");

        // random messages
        for (int m = 0; m < 4; m++) begin
            msg.delete();
            len = $urandom_range(1, 3);
            for (int i = 0; i < len; i++)
                msg.push_back('{d: 16'($urandom), c: 1'($urandom), l: (i == len - 1)});
            run_msg($sformatf("rand%0d", m));
        end

        // fill to DEPTH while the first word is on the line
        msg.delete();
        for (int i = 0; i <= DEPTH; i++)
            msg.push_back('{d: 16'($urandom), c: (i == 0), l: (i == DEPTH)});
        fork
            begin
                logic okf;
                for (int i = 0; i <= DEPTH; i++) begin
                    push(msg[i].d, msg[i].c, msg[i].l, okf);
                    check($sformatf("fill push %0d", i), okf, 1);
                    check($sformatf("fill level %0d", i), fifo_level, (i == 0) ? 1 : i);
                end
                check("full s_ready", bus.s_ready, 0);
                push(16'hDEAD, 1'b0, 1'b0, okf);
                check("push refused when full", okf, 0);
                check("level held at full", fifo_level, DEPTH);
            end
            check_msg("full");
        join
        check("full drained", fifo_level, 0);

        // inhibit while idle flushes without abort
        push(16'h5555, 1'b1, 1'b1, ok);
        check("idle-inh push", ok, 1);
        inh = 1'b1;
        @(negedge clk);
        check("idle-inh flush", fifo_level, 0);
        check("idle-inh no start", {busy, tx_en, aborted}, 0);
        push(16'h6666, 1'b1, 1'b1, ok);
        check("push ignored under inh", ok, 0);
        check("level under inh", fifo_level, 0);
        inh = 1'b0;
        n_tx = 0;
        repeat (20) begin n_tx += int'(tx_en); @(negedge clk); end
        check("idle-inh stays quiet", n_tx, 0);

        // abort mid-DATA
        push(16'h0F0F, 1'b1, 1'b0, ok);
        check("abort push0", ok, 1);
        push(16'hF0F0, 1'b0, 1'b1, ok);
        check("abort push1", ok, 1);
        wait_tx("abort", 10);
        repeat (300) @(negedge clk);
        check("abort pre level", fifo_level, 1);
        check("abort pre tx_en", tx_en, 1);
        inh = 1'b1;
        @(negedge clk);
        check("abort line cut", {TXP, TXN, tx_en}, 0);
        check("abort pulse", aborted, 1);
        check("abort flush", fifo_level, 0);
        check("abort s_ready", bus.s_ready, 0);
        @(negedge clk);
        check("abort pulse width", aborted, 0);
        inh = 1'b0;
        n_wd = 0; n_md = 0; n_tx = 0;
        repeat (GAP_CLK + 50) begin
            n_wd += int'(word_done);
            n_md += int'(msg_done);
            n_tx += int'(tx_en);
            @(negedge clk);
        end
        check("abort no word_done", n_wd, 0);
        check("abort no msg_done", n_md, 0);
        check("abort no restart", n_tx, 0);
        check("abort idle", busy, 0);

        // asynchronous reset mid-word
        push(16'h1357, 1'b0, 1'b0, ok);
        push(16'h2468, 1'b0, 1'b1, ok);
        wait_tx("reset-mid", 10);
        repeat (400) @(negedge clk);
        check("reset-mid pre level", fifo_level, 1);
        #2 rst_n = 1'b0;
        #1 check("reset-mid outputs", {TXP, TXN, tx_en, busy, word_done, msg_done, underrun, aborted}, 0);
        check("reset-mid level", fifo_level, 0);
        check("reset-mid s_ready", bus.s_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("reset-mid s_ready before clk", bus.s_ready, 0);
        @(negedge clk);
        check("reset-mid s_ready after clk", bus.s_ready, 1);
        check("reset-mid idle", {busy, tx_en}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
